// File: rtl/key_led_ctrl_pkg.sv
// Shared definitions for the key/LED controller: LED mode encodings and a
// helper that steps the mode sequencer.
package key_led_ctrl_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  // Mode FSM states, kept as plain constants so legacy code can compare
  // against raw 2-bit values.
  localparam mode_t MODE_OFF  = 2'd0;
  localparam mode_t MODE_ON   = 2'd1;
  localparam mode_t MODE_SLOW = 2'd2;
  localparam mode_t MODE_FAST = 2'd3;

  // OFF -> ON -> SLOW -> FAST -> OFF
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    unique case (cur)
      MODE_OFF:  nxt = MODE_ON;
      MODE_ON:   nxt = MODE_SLOW;
      MODE_SLOW: nxt = MODE_FAST;
      default:   nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

  function automatic logic mode_is_blink(input mode_t cur);
    return (cur == MODE_SLOW) || (cur == MODE_FAST);
  endfunction

endpackage

// File: rtl/key_led_ctrl_key_filter.sv
// key_filter: two-flop synchroniser plus debounce for an active-low push-button.
// Ports:
//   sys_clk   in  system clock
//   sys_rest  in  synchronous reset, active-high
//   key_in    in  raw asynchronous key, 0 = pressed
//   key_flag  out one-cycle pulse per accepted press
module key_filter #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rest,
  input  logic key_in,
  output logic key_flag
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CNT - 2);

  logic          key_meta_q;
  logic          key_sync_q;
  logic [CW-1:0] deb_cnt_q;
  logic          key_flag_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rest) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      deb_cnt_q  <= '0;
      key_flag_q <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_sync_q <= key_meta_q;
      // Saturating the count is what suppresses auto-repeat on a held key.
      if (key_sync_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q != CNT_MAX) begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
      key_flag_q <= !key_sync_q && (deb_cnt_q == CNT_ARM);
    end
  end

  assign key_flag = key_flag_q;

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced push-button stepping a 4-mode LED sequencer
// (OFF, ON, SLOW blink, FAST blink).
// Ports:
//   sys_clk   in  system clock
//   sys_rest  in  synchronous reset, active-high
//   key_in    in  raw asynchronous key, 0 = pressed
//   key_flag  out one-cycle pulse per accepted press
//   mode      out current LED mode
//   led_out   out LED drive, 1 = lit
module key_led_ctrl
  import key_led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT   = 1_000_000,
  parameter int unsigned BLINK_SLOW_CNT = 25_000_000,
  parameter int unsigned BLINK_FAST_CNT = 5_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rest,
  input  logic              key_in,
  output logic              key_flag,
  output logic [MODE_W-1:0] mode,
  output logic              led_out
);

  localparam int unsigned BLINK_MAX =
      (BLINK_SLOW_CNT > BLINK_FAST_CNT) ? BLINK_SLOW_CNT : BLINK_FAST_CNT;
  localparam int unsigned BW = $clog2(BLINK_MAX);
  localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_SLOW_CNT - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_FAST_CNT - 1);

  mode_t         mode_q, mode_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          blink_last;

  key_filter #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_key_filter (
    .sys_clk (sys_clk),
    .sys_rest(sys_rest),
    .key_in  (key_in),
    .key_flag(key_flag)
  );

  always_comb begin
    mode_d      = mode_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    blink_last  = (blink_cnt_q == ((mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST));
    // A press takes priority over a coincident phase wrap so every new mode
    // starts with a full lit phase.
    if (key_flag) begin
      mode_d      = next_mode(mode_q);
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (mode_is_blink(mode_q)) begin
      if (blink_last) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rest) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    led_out = 1'b0;
    unique case (mode_q)
      MODE_OFF: led_out = 1'b0;
      MODE_ON:  led_out = 1'b1;
      default:  led_out = phase_q;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: directed sequences, a vector table and random key
// traffic, all checked against a cycle-level behavioural model.
module tb_key_led_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SLOW = 10;
  localparam int unsigned FAST = 3;
  localparam int unsigned HIST = 8192;

  logic       sys_clk  = 1'b0;
  logic       sys_rest = 1'b1;
  logic       key_in   = 1'b1;
  logic       key_flag;
  logic [1:0] mode;
  logic       led_out;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  key_led_ctrl #(
    .DEBOUNCE_CNT  (DEB),
    .BLINK_SLOW_CNT(SLOW),
    .BLINK_FAST_CNT(FAST)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rest(sys_rest),
    .key_in  (key_in),
    .key_flag(key_flag),
    .mode    (mode),
    .led_out (led_out)
  );

  always #10 sys_clk = ~sys_clk;

  // Behavioural model: key history indexed by edge number, a low-run length
  // on the 2-edge-delayed key, a press counter and the edge each mode began.
  int unsigned edge_n   = 0;
  int unsigned last_rst = 0;
  bit          kin [HIST];
  int unsigned low_run  = 0;
  bit          m_flag   = 1'b0;
  int          m_mode   = 0;
  int unsigned m_start  = 0;

  task automatic model_step();
    bit ks;
    edge_n++;
    kin[edge_n % HIST] = key_in;
    if (sys_rest) begin
      last_rst = edge_n;
      low_run  = 0;
      m_flag   = 1'b0;
      m_mode   = 0;
      m_start  = edge_n;
    end else begin
      ks = (edge_n >= last_rst + 3) ? kin[(edge_n - 2) % HIST] : 1'b1;
      if (m_flag) begin
        m_mode  = (m_mode + 1) % 4;
        m_start = edge_n;
      end
      low_run = ks ? 0 : low_run + 1;
      m_flag  = !ks && (low_run == DEB - 1);
    end
  endtask

  function automatic int model_led();
    int unsigned j, n;
    if (m_mode == 0) return 0;
    if (m_mode == 1) return 1;
    n = (m_mode == 2) ? SLOW : FAST;
    j = edge_n - m_start;
    return ((j / n) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input int f, input int m, input int l);
    check({tag, ".flag"}, int'(key_flag), f);
    check({tag, ".mode"}, int'(mode), m);
    check({tag, ".led"}, int'(led_out), l);
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_step();
  end

  initial forever begin
    @(negedge sys_clk);
    if (chk_en) begin
      check("model.flag", int'(key_flag), int'(m_flag));
      check("model.mode", int'(mode), m_mode);
      check("model.led", int'(led_out), model_led());
    end
  end

  // Apply inputs for the next rising edge, return at the following falling edge.
  task automatic cyc(input logic r, input logic k);
    sys_rest = r;
    key_in   = k;
    @(negedge sys_clk);
  endtask

  // Six low edges: flag after the 5th, mode advances on the 6th.
  task automatic press();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
  endtask

  typedef struct {
    int low;
    int high;
    int exp_flags;
    int exp_mode;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{low: 1,  high: 2, exp_flags: 0, exp_mode: 1};
    vecs[1] = '{low: 2,  high: 1, exp_flags: 0, exp_mode: 1};
    vecs[2] = '{low: 3,  high: 1, exp_flags: 1, exp_mode: 2};
    vecs[3] = '{low: 4,  high: 2, exp_flags: 1, exp_mode: 3};
    vecs[4] = '{low: 2,  high: 4, exp_flags: 0, exp_mode: 3};
    vecs[5] = '{low: 7,  high: 1, exp_flags: 1, exp_mode: 0};
    vecs[6] = '{low: 10, high: 3, exp_flags: 1, exp_mode: 1};

    // Reset
    @(negedge sys_clk);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1);
    expect_out("reset", 0, 0, 0);
    cyc(1'b0, 1'b1);
    expect_out("reset.release", 0, 0, 0);

    // Clean press held 20 cycles
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b0);
      if (i < 5) check("press.early", int'(key_flag), 0);
      else if (i == 5) expect_out("press.flag", 1, 0, 0);
      else if (i == 6) expect_out("press.adv", 0, 1, 1);
      else check("press.no_repeat", int'(key_flag), 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);

    // Bounce: short low pulses never reach the debounce threshold
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, (i == 2 || i >= 5) ? 1'b1 : 1'b0);
      check("bounce.flag", int'(key_flag), 0);
    end
    check("bounce.mode", int'(mode), 1);

    // Vector table: low/high widths vs flags seen and resulting mode
    foreach (vecs[v]) begin
      int nflags;
      nflags = 0;
      for (int i = 0; i < vecs[v].low + vecs[v].high + 3; i++) begin
        cyc(1'b0, (i < vecs[v].low) ? 1'b0 : 1'b1);
        if (key_flag) nflags++;
      end
      check($sformatf("vec%0d.flags", v), nflags, vecs[v].exp_flags);
      check($sformatf("vec%0d.mode", v), int'(mode), vecs[v].exp_mode);
    end

    // Blink: ON -> SLOW -> FAST -> OFF
    press();
    for (int j = 0; j < 40; j++) begin
      check("slow.mode", int'(mode), 2);
      check("slow.led", int'(led_out), ((j / 10) % 2 == 0) ? 1 : 0);
      cyc(1'b0, 1'b1);
    end
    press();
    for (int j = 0; j < 12; j++) begin
      check("fast.mode", int'(mode), 3);
      check("fast.led", int'(led_out), ((j / 3) % 2 == 0) ? 1 : 0);
      cyc(1'b0, 1'b1);
    end
    press();
    expect_out("off", 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);

    // Press landing on a SLOW wrap where phase would fall to 0
    press();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    press();
    check("wrap.in_slow", int'(mode), 2);
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1);
    press();
    for (int j = 0; j < 4; j++) begin
      check("wrap.mode", int'(mode), 3);
      check("wrap.led", int'(led_out), (j < 3) ? 1 : 0);
      cyc(1'b0, 1'b1);
    end

    // Reset mid-count while in FAST
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    check("rst_mid.pre_mode", int'(mode), 3);
    cyc(1'b1, 1'b0);
    expect_out("rst_mid", 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0);
      if (i < 5) check("rst_mid.early", int'(key_flag), 0);
      else if (i == 5) expect_out("rst_mid.flag", 1, 0, 0);
      else expect_out("rst_mid.adv", 0, 1, 1);
    end

    // Random key traffic with occasional reset, checked by the model
    for (int s = 0; s < 150; s++) begin
      int lo, hi;
      bit rst;
      lo  = $urandom_range(1, 8);
      hi  = $urandom_range(1, 20);
      rst = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < lo; i++) cyc((rst && i == lo / 2) ? 1'b1 : 1'b0, 1'b0);
      for (int i = 0; i < hi; i++) cyc(1'b0, 1'b1);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
